serial_deserialiser: RTL and testbench
======================================

# serial_deserialiser

Bit-serial framed-stream receiver that sits directly upstream of the clock-crossing FIFO, in that FIFO's write clock domain. It hunts for a sync pattern and packs the following payload bits MSB-first into WIDTH-bit words. Each completed word goes out on a FIFO write port that matches the FIFO's write side. The serial source cannot be stalled: a word that completes while the FIFO is full is dropped and reported.

## Interface
Parameters:
- WIDTH, 32: payload word width; must be ≥ 2.
- SYNC_WIDTH, 16: sync pattern length in bits; must be ≥ 2.
- SYNC_WORD, 16'hA5C3: sync pattern, SYNC_WIDTH bits, MSB received first.
- FRAME_WORDS, 4: payload words per frame; must be ≥ 1.
- CNT_WIDTH, 16: width of the status counters.

Ports:
- wr_clk  in  1  sole clock.
- wr_rst_n  in  1  reset; synchronous, active-low.
- ser_valid  in  1  ser_data carries a bit this cycle.
- ser_data  in  1  serial bit.
- fifo_wr_en  out  1  write strobe to the FIFO.
- fifo_wr_data  out  WIDTH  word being written.
- fifo_full  in  1  FIFO full flag.
- in_frame  out  1  high while receiving payload.
- frame_done  out  1  one-cycle pulse when a frame's last word is issued or dropped.
- overflow  out  1  sticky flag: at least one word was dropped.
- clr_overflow  in  1  clears overflow.
- frame_cnt  out  CNT_WIDTH  completed frames; saturating.
- drop_cnt  out  CNT_WIDTH  dropped words; saturating.

## Operation
- The FSM has two states, HUNT and PAYLOAD; reset enters HUNT.
- HUNT:
  - On each ser_valid, sync_sr <= {sync_sr[SYNC_WIDTH-2:0], ser_data}.
  - If the shifted value equals SYNC_WORD, the next state is PAYLOAD; sync_sr, bit_cnt and word_cnt clear.
  - Leading garbage bits before the pattern are tolerated.
- PAYLOAD:
  - On each ser_valid, data_sr shifts the bit in at the LSB, so the first bit lands at the MSB; bit_cnt increments.
  - On the bit where bit_cnt == WIDTH-1:
    - the completed word is registered into fifo_wr_data;
    - word_valid is set for one cycle;
    - bit_cnt wraps to 0 and word_cnt increments.
  - When the completing word has word_cnt == FRAME_WORDS-1, the next state is HUNT.
- Issue/drop, in the cycle where word_valid = 1:
  - fifo_wr_en = word_valid & ~fifo_full, combinational from word_valid.
  - If fifo_full = 1, the word is dropped: overflow <= 1 and drop_cnt increments, saturating at all-ones.
  - A dropped word still counts toward the frame.
- Frame end:
  - frame_done pulses in the same cycle as the last word's issue/drop.
  - frame_cnt increments, saturating.
- clr_overflow clears overflow. If a drop occurs in the same cycle, set wins.
- While ser_valid = 0, no shift occurs and all counters and the state hold.
- Reset, including mid-frame:
  - state returns to HUNT; the partial word is discarded;
  - all shift registers and counters clear;
  - all outputs are 0.

## Timing
- Latency: last bit of a word accepted in cycle N → fifo_wr_en (or the drop) in cycle N+1.
- fifo_full is sampled in cycle N+1, not N.
- fifo_wr_en never asserts on consecutive cycles, because a word needs at least 2 bits.
- fifo_wr_data holds its last value between writes.
- in_frame is registered: it rises the cycle after the final sync bit and falls the cycle after the last payload bit.
- frame_done and the frame_cnt update are coincident with the last word's N+1 cycle.

## Structure
- Package deser_pkg holds:
  - typedef enum deser_state_e {HUNT, PAYLOAD};
  - the default SYNC_WORD constant.
- Sub-module sat_counter (parameter CNT_WIDTH; inputs inc and clear; saturating count output) is instantiated twice, for frame_cnt and drop_cnt.

## Test plan
- Reset → every output is 0 and in_frame = 0; the ser_data sequence 16'h0000 produces no detection.
- Frame with fifo_full = 0:
  - Stimulus: bits 4'b1011, then 16'hA5C3, then 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D.
  - Response: four fifo_wr_en pulses, each 1 cycle after the 32nd bit of its word, with matching data.
  - frame_done coincides with the 4th pulse; frame_cnt = 1; in_frame falls.
- Near-miss sync 16'hA5C2 followed by 128 payload bits → no writes, in_frame stays 0, frame_cnt = 0.
- fifo_full = 1 in the issue cycle of word 2:
  - Words 1, 3 and 4 are written; overflow = 1, drop_cnt = 1, frame_cnt = 1.
  - A subsequent clr_overflow pulse clears overflow.
  - clr_overflow in the same cycle as a drop leaves overflow = 1.
- Random ser_valid gaps throughout the frame → identical words and order; latency is still 1 cycle from the last valid bit.
- wr_rst_n low after 10 bits of word 2:
  - No further writes; in_frame = 0; all counters = 0.
  - A following sync plus full frame is received cleanly, with frame_cnt = 1.

Source files
------------

// File: rtl/serial_deserialiser_pkg.sv
// Shared types and constants for the framed serial receiver.
package deser_pkg;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } deser_state_e;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5C3;

endpackage

// File: rtl/serial_deserialiser_if.sv
// Serial input and FIFO write port of the deserialiser, in the FIFO write clock domain.
//
// Handshake: ser_valid qualifies ser_data for exactly one cycle and is never
// back-pressured. fifo_wr_en is a single-cycle strobe qualifying fifo_wr_data;
// it is only raised while fifo_full is low, otherwise the word is dropped.
interface serial_deserialiser_if #(
  parameter int WIDTH = 32
) ();

  logic             ser_valid;
  logic             ser_data;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic             fifo_full;

  modport master (
    input  ser_valid,
    input  ser_data,
    input  fifo_full,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    output ser_valid,
    output ser_data,
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_wr_data
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_deserialiser.sv
// Hunts for a sync pattern on a bit-serial stream, then packs FRAME_WORDS
// payload words MSB-first and writes them to a FIFO, dropping words when full.
module serial_deserialiser
  import deser_pkg::*;
#(
  parameter int                    WIDTH       = 32,
  parameter int                    SYNC_WIDTH  = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = SYNC_WIDTH'(DEFAULT_SYNC_WORD),
  parameter int                    FRAME_WORDS = 4,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  serial_deserialiser_if.master  bus,
  output logic                   in_frame,
  output logic                   frame_done,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [CNT_WIDTH-1:0]   frame_cnt,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output deser_state_e           state_dbg
);

  localparam int BW = $clog2(WIDTH);
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  deser_state_e          state;
  // Only the low bits are kept; the oldest bit falls out of each shift.
  logic [SYNC_WIDTH-2:0] sync_sr;
  logic [WIDTH-2:0]      data_sr;
  logic [BW-1:0]         bit_cnt;
  logic [WW-1:0]         word_cnt;
  logic                  word_valid;
  logic [WIDTH-1:0]      wr_data;

  logic [SYNC_WIDTH-1:0] sync_next;
  logic [WIDTH-1:0]      data_next;
  logic                  word_end;
  logic                  frame_end;
  logic                  drop;

  assign sync_next = {sync_sr, bus.ser_data};
  assign data_next = {data_sr, bus.ser_data};
  assign word_end  = bus.ser_valid && (state == PAYLOAD) && (bit_cnt == BIT_LAST);
  assign frame_end = word_end && (word_cnt == WORD_LAST);

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state      <= HUNT;
      sync_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      wr_data    <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      if (bus.ser_valid) begin
        case (state)
          HUNT: begin
            if (sync_next == SYNC_WORD) begin
              state    <= PAYLOAD;
              sync_sr  <= '0;
              bit_cnt  <= '0;
              word_cnt <= '0;
            end else begin
              sync_sr <= sync_next[SYNC_WIDTH-2:0];
            end
          end
          PAYLOAD: begin
            data_sr <= data_next[WIDTH-2:0];
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
              wr_data    <= data_next;
              word_valid <= 1'b1;
              if (word_cnt == WORD_LAST) begin
                word_cnt   <= '0;
                state      <= HUNT;
                frame_done <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // fifo_full is looked at in the issue cycle, one cycle after the last bit.
  assign drop             = word_valid & bus.fifo_full;
  assign bus.fifo_wr_en   = word_valid & ~bus.fifo_full;
  assign bus.fifo_wr_data = wr_data;

  // A drop in the same cycle as a clear wins, so no drop goes unreported.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign in_frame  = (state == PAYLOAD);
  assign state_dbg = state;

  // Counting on the completing bit lets frame_cnt change alongside frame_done.
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (wr_clk),
    .clear (~wr_rst_n),
    .inc   (frame_end),
    .count (frame_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (wr_clk),
    .clear (~wr_rst_n),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_serial_deserialiser.sv
// Directed bench for serial_deserialiser: sync hunt, packing, drops, gaps and reset.
module tb_serial_deserialiser;
  import deser_pkg::*;

  localparam int W = 32;

  logic         wr_clk = 1'b0;
  logic         wr_rst_n;
  logic         clr_overflow;
  logic         in_frame;
  logic         frame_done;
  logic         overflow;
  logic [15:0]  frame_cnt;
  logic [15:0]  drop_cnt;
  deser_state_e state_dbg;

  serial_deserialiser_if #(.WIDTH(W)) bus_if ();

  serial_deserialiser dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .bus          (bus_if),
    .in_frame     (in_frame),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 wr_clk = ~wr_clk;

  int cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           exp_cyc_q[$];
  int           got_cyc_q[$];
  int           consec_cnt = 0;
  logic         prev_wr = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  always @(negedge wr_clk) begin
    if (bus_if.fifo_wr_en === 1'b1) begin
      got_q.push_back(bus_if.fifo_wr_data);
      got_cyc_q.push_back(cyc);
      if (prev_wr) consec_cnt++;
    end
    prev_wr = (bus_if.fifo_wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic pend_full = 1'b0;
  logic pend_clr  = 1'b0;

  // Inputs change 1 ns after the rising edge; the issue-cycle flags apply to
  // whichever cycle follows the one that set them.
  task automatic drive_cycle(input logic v, input logic d);
    bus_if.ser_valid = v;
    bus_if.ser_data  = d;
    bus_if.fifo_full = pend_full;
    clr_overflow     = pend_clr;
    pend_full        = 1'b0;
    pend_clr         = 1'b0;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_cycle(1'b1, v[i]);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic full, input logic clr,
                           input logic gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 1'($urandom_range(0, 1)));
      drive_cycle(1'b1, w[i]);
    end
    pend_full = full;
    pend_clr  = clr;
    if (!full) begin
      exp_q.push_back(w);
      exp_cyc_q.push_back(cyc);
    end
  endtask

  logic [W-1:0] frame_words[4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};

  task automatic send_frame(input int drop_idx, input int clr_idx, input logic gaps);
    send_bits(32'h0000A5C3, 16);
    check("in_frame_after_sync", 64'(in_frame), 64'd1);
    check("state_payload", 64'(state_dbg), 64'(PAYLOAD));
    for (int k = 0; k < 4; k++) begin
      send_word(frame_words[k], (k == drop_idx), (k == clr_idx), gaps);
      if (k < 3) begin
        check("frame_done_mid", 64'(frame_done), 64'd0);
      end else begin
        check("frame_done_last", 64'(frame_done), 64'd1);
        check("in_frame_fall", 64'(in_frame), 64'd0);
      end
    end
  endtask

  task automatic compare_words(input string tag);
    idle(3);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_data"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      check({tag, "_latency"}, 64'(got_cyc_q.pop_front()), 64'(exp_cyc_q.pop_front()));
    end
    got_q.delete(); exp_q.delete(); got_cyc_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    idle(3);
    check("rst_wr_en", 64'(bus_if.fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(bus_if.fifo_wr_data), 64'd0);
    check("rst_in_frame", 64'(in_frame), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(HUNT));
    wr_rst_n = 1'b1;
    idle(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wr_rst_n         = 1'b0;
    clr_overflow     = 1'b0;
    bus_if.ser_valid = 1'b0;
    bus_if.ser_data  = 1'b0;
    bus_if.fifo_full = 1'b0;
    @(posedge wr_clk);
    #1;
    do_reset();

    // All-zero stream never matches the sync pattern.
    send_bits(32'h0, 16);
    check("zeros_no_sync", 64'(in_frame), 64'd0);

    // Near-miss sync followed by zeros: A5C2 shifted left never becomes A5C3.
    send_bits(32'h0000A5C2, 16);
    check("nearmiss_in_frame", 64'(in_frame), 64'd0);
    for (int i = 0; i < 4; i++) send_bits(32'h0, 32);
    check("nearmiss_in_frame_end", 64'(in_frame), 64'd0);
    compare_words("nearmiss");
    check("nearmiss_frame_cnt", 64'(frame_cnt), 64'd0);

    // Clean frame preceded by garbage bits.
    send_bits(32'hB, 4);
    send_frame(-1, -1, 1'b0);
    compare_words("clean");
    check("clean_frame_cnt", 64'(frame_cnt), 64'd1);
    check("clean_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clean_overflow", 64'(overflow), 64'd0);

    // FIFO full in the issue cycle of word 2.
    do_reset();
    send_frame(1, -1, 1'b0);
    compare_words("drop");
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_drop_cnt", 64'(drop_cnt), 64'd1);
    check("drop_frame_cnt", 64'(frame_cnt), 64'd1);
    pend_clr = 1'b1;
    idle(1);
    check("clr_overflow", 64'(overflow), 64'd0);

    // Clear coincident with a drop: the drop wins.
    send_frame(0, 0, 1'b0);
    compare_words("drop_clr");
    check("drop_clr_overflow", 64'(overflow), 64'd1);
    check("drop_clr_drop_cnt", 64'(drop_cnt), 64'd2);
    check("drop_clr_frame_cnt", 64'(frame_cnt), 64'd2);

    // Random ser_valid gaps throughout the frame.
    send_frame(-1, -1, 1'b1);
    compare_words("gaps");
    check("gaps_frame_cnt", 64'(frame_cnt), 64'd3);

    // Reset after 10 bits of word 2: partial word is discarded.
    send_bits(32'h0000A5C3, 16);
    send_word(frame_words[0], 1'b0, 1'b0, 1'b0);
    send_bits(frame_words[1] >> 22, 10);
    do_reset();
    compare_words("midrst");
    send_frame(-1, -1, 1'b0);
    compare_words("after_rst");
    check("after_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    check("no_back_to_back_writes", 64'(consec_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
